// File: rtl/axi4_lite.sv
// AXI4-Lite slave with four 32-bit read/write registers.
// REG0 bit 0 drives gpio_o. One outstanding transaction per channel;
// read and write channels operate independently.
module axi4_lite #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    gpio_o
);

    localparam int         NUM_REGS = 4;
    localparam int         NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_ready_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  ar_ready_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            raddr_reg;
    logic                  rerr_reg;

    logic                  wr_fire;
    logic                  wr_in_range;
    logic                  rd_fire;
    logic                  rd_in_range;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] wr_mask;

    // Byte offset bits are ignored by the register decode.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A write is taken only when address and data arrive together and the
    // previous write has fully retired (accept pulse done, response taken).
    assign wr_fire     = s_axi_awvalid && s_axi_wvalid && !aw_ready_reg && !bvalid_reg;
    assign wr_in_range = (s_axi_awaddr[ADDR_WIDTH-1:4] == '0);
    assign rd_fire     = s_axi_arvalid && !ar_ready_reg && !rvalid_reg;
    assign rd_in_range = (s_axi_araddr[ADDR_WIDTH-1:4] == '0);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign wr_sel[gi] = wr_fire && wr_in_range && (s_axi_awaddr[3:2] == 2'(gi));
        end
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
            assign wr_mask[gi*8 +: 8] = {8{s_axi_wstrb[gi]}};
        end
    endgenerate

    // Register file: byte-masked update on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= (regs[i] & ~wr_mask) | (s_axi_wdata & wr_mask);
                end
            end
        end
    end

    // Write channel: one-cycle accept pulse, then response held until bready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_ready_reg <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            aw_ready_reg <= wr_fire;
            if (wr_fire) begin
                bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (aw_ready_reg) begin
                bvalid_reg <= 1'b1;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read channel: latch address, sample the register one edge later so a
    // write committed on the capture edge is visible, hold data until rready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_ready_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= RESP_OKAY;
            rdata_reg    <= '0;
            raddr_reg    <= '0;
            rerr_reg     <= 1'b0;
        end else begin
            ar_ready_reg <= rd_fire;
            if (rd_fire) begin
                raddr_reg <= s_axi_araddr[3:2];
                rerr_reg  <= !rd_in_range;
            end
            if (ar_ready_reg) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rerr_reg ? '0 : regs[raddr_reg];
                rresp_reg  <= rerr_reg ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_reg && s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axi_awready = aw_ready_reg;
    assign s_axi_wready  = aw_ready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_arready = ar_ready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rdata   = rdata_reg;
    assign gpio_o        = regs[0][0];

endmodule

// File: tb/tb_axi4_lite.sv
// Directed testbench for axi4_lite. Expected responses are queued when a
// transaction is issued; monitors pop and compare on each handshake.
module tb_axi4_lite;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        gpio;

    int vec_count = 0;
    int miscompares = 0;

    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];

    axi4_lite #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .gpio_o(gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Write response monitor.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (b_exp_q.size() == 0) begin
                vec_count++;
                miscompares++;
                $display("FAIL bresp_unexpected: got response %b expected none", bresp);
            end else begin
                check("bresp", 32'(bresp), 32'(b_exp_q.pop_front()));
            end
        end
    end

    // Read response monitor.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (r_exp_q.size() == 0) begin
                vec_count++;
                miscompares++;
                $display("FAIL rdata_unexpected: got %h expected none", rdata);
            end else begin
                logic [33:0] e;
                e = r_exp_q.pop_front();
                check("rdata", rdata, e[33:2]);
                check("rresp", 32'(rresp), 32'(e[1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp);
        int n;
        b_exp_q.push_back(exp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        check("awready", 32'(awready), 32'd1);
        check("wready", 32'(wready), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("awready_pulse", 32'(awready), 32'd0);
        check("bvalid_rise", 32'(bvalid), 32'd1);
        n = 0;
        while (bvalid && n < 50) begin tick(); n++; end
        check("bvalid_clear", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n;
        r_exp_q.push_back({exp_d, exp_r});
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!arready && n < 20);
        check("arready", 32'(arready), 32'd1);
        arvalid = 1'b0;
        tick();
        check("arready_pulse", 32'(arready), 32'd0);
        check("rvalid_rise", 32'(rvalid), 32'd1);
        n = 0;
        while (rvalid && n < 50) begin tick(); n++; end
        check("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gpio", 32'(gpio), 32'd0);
        rst_n = 1'b1;
        tick();
        do_read(8'h00, 32'h0000_0000, 2'b00);

        // Full write to REG0, gpio follows bit 0.
        do_write(8'h00, 32'hDEAD_BEEF, 4'hF, 2'b00);
        check("gpio_set", 32'(gpio), 32'd1);
        do_read(8'h00, 32'hDEAD_BEEF, 2'b00);

        // Partial byte-strobe write.
        do_write(8'h04, 32'hFFFF_FFFF, 4'hF, 2'b00);
        do_write(8'h04, 32'h1234_5678, 4'h3, 2'b00);
        do_read(8'h04, 32'hFFFF_5678, 2'b00);
        do_read(8'h07, 32'hFFFF_5678, 2'b00);

        // Clear REG0, then out-of-range accesses.
        do_write(8'h00, 32'h0000_0000, 4'hF, 2'b00);
        check("gpio_clear", 32'(gpio), 32'd0);
        do_write(8'h20, 32'hCAFE_F00D, 4'hF, 2'b10);
        do_read(8'h00, 32'h0000_0000, 2'b00);
        do_read(8'h04, 32'hFFFF_5678, 2'b00);
        do_read(8'h20, 32'h0000_0000, 2'b10);

        // Backpressure with concurrent write and read of REG2 on the same edge.
        bready = 1'b0; rready = 1'b0;
        b_exp_q.push_back(2'b00);
        r_exp_q.push_back({32'hA5A5_A5A5, 2'b00});
        awaddr = 8'h08; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        tick();
        check("bp_awready", 32'(awready), 32'd1);
        check("bp_arready", 32'(arready), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("bp_bvalid_rise", 32'(bvalid), 32'd1);
        check("bp_rvalid_rise", 32'(rvalid), 32'd1);
        awaddr = 8'h0C; wdata = 32'h1111_1111; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_bvalid_hold", 32'(bvalid), 32'd1);
            check("bp_rvalid_hold", 32'(rvalid), 32'd1);
            check("bp_rdata_hold", rdata, 32'hA5A5_A5A5);
            check("bp_no_aw_accept", 32'(awready), 32'd0);
            check("bp_no_ar_accept", 32'(arready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick();
        check("bp_bvalid_clear", 32'(bvalid), 32'd0);
        check("bp_rvalid_clear", 32'(rvalid), 32'd0);
        do_read(8'h0C, 32'h0000_0000, 2'b00);

        // Lone awvalid must wait for wvalid.
        awaddr = 8'h0C; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lone_aw_wait", 32'(awready), 32'd0);
        end
        b_exp_q.push_back(2'b00);
        wvalid = 1'b1;
        tick();
        check("lone_aw_accept", 32'(awready), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("lone_aw_bvalid", 32'(bvalid), 32'd1);
        tick();
        check("lone_aw_bclear", 32'(bvalid), 32'd0);
        do_read(8'h0C, 32'h0BAD_F00D, 2'b00);

        // Reset in the middle of a pending write response.
        bready = 1'b0;
        awaddr = 8'h00; wdata = 32'h0000_0001; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        check("mid_awready", 32'(awready), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("mid_bvalid", 32'(bvalid), 32'd1);
        check("mid_gpio", 32'(gpio), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_gpio", 32'(gpio), 32'd0);
        rst_n = 1'b1;
        bready = 1'b1;
        tick();
        do_read(8'h04, 32'h0000_0000, 2'b00);

        repeat (2) tick();
        check("b_queue_empty", 32'(b_exp_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
